// File: rtl/psd_seqmultiply.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Optional two's-complement operands when PSDMULT_SIGNED_EN is defined.
module psd_seqmultiply #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    mcand_reg;
  logic [WIDTH-1:0]    acc_reg;
  logic [WIDTH-1:0]    mplr_reg;
  logic [CW-1:0]       count_reg;
  logic [2*WIDTH-1:0]  product_reg;
  logic                accept;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  shifted;
  logic [2*WIDTH-1:0]  result;
  logic [WIDTH-1:0]    a_load, b_load;

`ifdef PSDMULT_SIGNED_EN
  logic neg_reg;
  // Magnitudes fit in WIDTH unsigned bits, including |-2^(W-1)|.
  assign a_load = multiplicand[WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
  assign b_load = multiplier[WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
  assign result = neg_reg ? (~shifted + 1'b1) : shifted;
`else
  assign a_load = multiplicand;
  assign b_load = multiplier;
  assign result = shifted;
`endif

  assign accept  = start && (state_reg != RUN);
  assign sum     = {1'b0, acc_reg} + {1'b0, (mplr_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  assign shifted = {sum, mplr_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_reg == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      mplr_reg    <= '0;
      count_reg   <= '0;
      product_reg <= '0;
`ifdef PSDMULT_SIGNED_EN
      neg_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mcand_reg <= a_load;
        acc_reg   <= '0;
        mplr_reg  <= b_load;
        count_reg <= '0;
`ifdef PSDMULT_SIGNED_EN
        neg_reg   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
      end else if (state_reg == RUN) begin
        acc_reg   <= shifted[2*WIDTH-1:WIDTH];
        mplr_reg  <= shifted[WIDTH-1:0];
        count_reg <= count_reg + CW'(1);
        // Product is written on the same edge that raises done.
        if (count_reg == LAST) product_reg <= result;
      end
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule
